pulse_rate_meter: RTL and testbench
===================================

# pulse_rate_meter

Measures the rate of an external pulse train by counting its rising edges over a fixed gate window derived from `clock` (1 s at 50 MHz by default). At the end of each window it latches the count for display. It is the receiving counterpart of the rate-divider/counter chain: that chain produces ticks, and this block measures them. Typical use is a board top that feeds a GPIO, or a looped-back enable pulse, into `sig_in` and drives two HEX digits from `count_out`.

## Interface
- `GATE_CYCLES`, default 50000000: window length in `clock` cycles; must be ≥ 2.
- `CNT_WIDTH`, default 8: width of the edge counter and `count_out`.
- `clock` in 1: single clock domain (CLOCK_50 at top level).
- `reset` in 1: asynchronous, active-low; clears all state.
- `enable` in 1: synchronous; 1 = measure, 0 = idle.
- `sig_in` in 1: asynchronous pulse input.
- `count_out` out CNT_WIDTH: rising edges counted in the last completed window.
- `overflow` out 1: last completed window saturated.
- `valid` out 1: one-cycle strobe; `count_out` and `overflow` were updated this cycle.

## Operation
- **Synchronizer.** `sig_in` passes through two flops (`s1`, `s2`), then a history flop `s3`. A rising edge is detected when `s2 & ~s3`. All three flops reset to 0, so an input already high at reset release counts as one edge.
- **FSM states.** There are two states, IDLE and MEASURE, and the reset state is IDLE.
  - IDLE to MEASURE when `enable` = 1.
  - MEASURE to IDLE when `enable` = 0. This takes priority over everything, including the window-end cycle, and no latch happens.
  - In IDLE, `gate_cnt` and `edge_cnt` are held at 0, and `count_out` and `overflow` keep their last values.
- **Gate counter.** `gate_cnt` has width $clog2(GATE_CYCLES). It counts 0 to GATE_CYCLES-1 in MEASURE and wraps to 0.
- **Edge counter.** `edge_cnt` increments on each detected edge and saturates at 2^CNT_WIDTH-1.
  - The sticky `ovf` flag sets when an edge arrives while `edge_cnt` is already at its maximum.
- **Window end** (`gate_cnt == GATE_CYCLES-1` in MEASURE):
  - `count_out` ← saturated(`edge_cnt` + edge_this_cycle).
  - `overflow` ← `ovf` OR (`edge_cnt` is at max AND there is an edge this cycle).
  - `valid` ← 1 for exactly one cycle.
  - `edge_cnt` ← 0 and `ovf` ← 0 in the same cycle. An edge on this cycle belongs to the ending window.
- Windows run back-to-back with no dead cycle.

## Timing
- **Reset values.** `count_out` = 0, `overflow` = 0, `valid` = 0, state IDLE, all counters 0.
- **Edge latency.** A `sig_in` rising edge that meets setup before clock edge k is counted on edge k+2. `s1` samples at k, `s2` at k+1, and the detection is registered into `edge_cnt` at k+2.
- **Minimum pulse.** `sig_in` must stay high ≥ 1 cycle and low ≥ 1 cycle; narrower pulses may be missed.
- **First window.** If `enable` is first seen high at edge e, MEASURE starts with `gate_cnt` = 0 after e. `valid` is first asserted GATE_CYCLES cycles after that, on the cycle after the window-end edge.
- **Output timing.** `valid` and `count_out` are registered and change on the same edge.
- **Mid-operation reset or disable.** Reset mid-window discards the partial count and clears the outputs. Disabling (`enable` = 0) mid-window discards the partial count and keeps the outputs.

## Structure
- The shared package holds:
  - the gate constants `GATE_1S` = 50000000, `GATE_HALF_S` = 25000000 and `GATE_2S` = 100000000, matching the board rate selections;
  - the state enum `{IDLE, MEASURE}`.
- One sub-module, `sync_edge_detect`: the two-flop synchronizer plus history flop, outputting a one-cycle `rise` pulse. It is reusable for KEY inputs.
- The hex display decode stays outside this block.

## Test plan
All scenarios use GATE_CYCLES = 20 and CNT_WIDTH = 4.
- **Reset.** Assert `reset` = 0 mid-run → all outputs 0 immediately, with no clock needed. Release with `enable` = 1 → first `valid` after 20 cycles.
- **Basic count.** 5 pulses (2 cycles high, 2 low) inside one window → `valid` with `count_out` = 5, `overflow` = 0. The next window with no pulses gives `count_out` = 0.
- **Saturation.** 18 edges in one window (1 cycle high, 1 low would give 10; use 2 windows' worth via GATE_CYCLES = 40) → `count_out` = 15, `overflow` = 1. The following clean window of 3 edges gives 3 with `overflow` = 0.
- **Boundary edge.** Edge detected exactly on the window-end cycle → counted in the ending window (4 + 1 = 5), and the next window starts from 0.
- **Disable mid-window.** Drop `enable` at cycle 10 after 3 edges → no `valid`, `count_out` keeps its previous value. Re-enabling starts a full 20-cycle window.
- **Async input.** `sig_in` rising between clock edges → count is correct, and detection latency is 2 to 3 cycles, checked against a model.

Source files
------------

// File: rtl/pulse_rate_meter_pkg.sv
// Shared constants and types for the pulse rate meter.
// Gate lengths match the board's rate selections at 50 MHz.
package pulse_rate_meter_pkg;

  localparam int GATE_1S     = 50000000;
  localparam int GATE_HALF_S = 25000000;
  localparam int GATE_2S     = 100000000;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus history flop; rise is a one-cycle pulse per rising edge.
// All flops clear on reset, so an input already high at reset release yields one rise.
module sync_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/pulse_rate_meter.sv
// Counts rising edges of sig_in over a fixed gate window of GATE_CYCLES clocks
// and latches the (saturated) count and overflow flag at each window end.
module pulse_rate_meter
  import pulse_rate_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_1S,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] count_out,
  output logic                 overflow,
  output logic                 valid
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]        GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  meter_state_t         state;
  logic [GW-1:0]        gate_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 ovf;
  logic                 rise;
  logic                 at_max;
  logic                 window_end;

  sync_edge_detect u_sync (
    .clock  (clock),
    .reset  (reset),
    .sig_in (sig_in),
    .rise   (rise)
  );

  assign at_max     = (edge_cnt == CNT_MAX);
  assign window_end = (state == MEASURE) && enable && (gate_cnt == GATE_LAST);

  // With two states the next state is simply whatever enable asks for.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= enable ? MEASURE : IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else if ((state != MEASURE) || !enable || window_end) begin
      gate_cnt <= '0;
      edge_cnt <= '0;
      ovf      <= 1'b0;
    end else begin
      gate_cnt <= gate_cnt + GW'(1);
      if (rise) begin
        if (at_max) begin
          ovf <= 1'b1;
        end else begin
          edge_cnt <= edge_cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

  // An edge on the window-end cycle still belongs to the window that is closing.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_out <= '0;
      overflow  <= 1'b0;
      valid     <= 1'b0;
    end else begin
      valid <= window_end;
      if (window_end) begin
        count_out <= (rise && !at_max) ? edge_cnt + CNT_WIDTH'(1) : edge_cnt;
        overflow  <= ovf | (at_max & rise);
      end
    end
  end

endmodule

// File: tb/tb_pulse_rate_meter.sv
// Bench for pulse_rate_meter: two instances (20- and 40-cycle gates, 4-bit count)
// compared every cycle against an arithmetic model, plus literal scenario checks.
module tb_pulse_rate_meter;

  localparam int G_A  = 20;
  localparam int G_B  = 40;
  localparam int CW   = 4;
  localparam int CMAX = 15;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          sig_in;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;
  logic          ovf_a;
  logic          ovf_b;
  logic          valid_a;
  logic          valid_b;

  int n_compared = 0;
  int n_failed   = 0;

  always #5 clock = ~clock;

  pulse_rate_meter #(.GATE_CYCLES(G_A), .CNT_WIDTH(CW)) dut_a (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .count_out (count_a),
    .overflow  (ovf_a),
    .valid     (valid_a)
  );

  pulse_rate_meter #(.GATE_CYCLES(G_B), .CNT_WIDTH(CW)) dut_b (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .sig_in    (sig_in),
    .count_out (count_b),
    .overflow  (ovf_b),
    .valid     (valid_b)
  );

  // Model: hist holds sig_in as seen at the last three clock edges; an edge is
  // credited two edges after it was first sampled high. Counts are kept raw
  // and clipped only when a window closes.
  int  gate_len [2] = '{G_A, G_B};
  bit  hist [3];
  bit  model_edge;
  bit  m_measure [2];
  int  m_pos [2];
  int  m_raw [2];
  int  m_count [2];
  bit  m_ovf [2];
  bit  m_valid [2];

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) hist[i] = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_measure[d] = 1'b0;
        m_pos[d]     = 0;
        m_raw[d]     = 0;
        m_count[d]   = 0;
        m_ovf[d]     = 1'b0;
        m_valid[d]   = 1'b0;
      end
    end else begin
      model_edge = hist[1] & ~hist[2];
      for (int d = 0; d < 2; d++) begin
        m_valid[d] = 1'b0;
        if (!m_measure[d]) begin
          if (enable) begin
            m_measure[d] = 1'b1;
            m_pos[d]     = 0;
            m_raw[d]     = 0;
          end
        end else if (!enable) begin
          m_measure[d] = 1'b0;
        end else begin
          m_raw[d] = m_raw[d] + int'(model_edge);
          if (m_pos[d] == gate_len[d] - 1) begin
            m_count[d] = (m_raw[d] > CMAX) ? CMAX : m_raw[d];
            m_ovf[d]   = (m_raw[d] > CMAX);
            m_valid[d] = 1'b1;
            m_raw[d]   = 0;
            m_pos[d]   = 0;
          end else begin
            m_pos[d] = m_pos[d] + 1;
          end
        end
      end
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = sig_in;
    end
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_compared++;
    if (actual != expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    check_output("count_a", int'(count_a), m_count[0]);
    check_output("ovf_a",   int'(ovf_a),   int'(m_ovf[0]));
    check_output("valid_a", int'(valid_a), int'(m_valid[0]));
    check_output("count_b", int'(count_b), m_count[1]);
    check_output("ovf_b",   int'(ovf_b),   int'(m_ovf[1]));
    check_output("valid_b", int'(valid_b), int'(m_valid[1]));
  end

  // Inputs change a random 1-3 time units after the falling edge, never near the rising edge.
  task automatic step();
    @(negedge clock);
    #($urandom_range(1, 3));
  endtask

  task automatic apply_stimulus(input int pulses, input int hi, input int lo);
    for (int p = 0; p < pulses; p++) begin
      sig_in = 1'b1;
      repeat (hi) step();
      sig_in = 1'b0;
      repeat (lo) step();
    end
  endtask

  task automatic start_window();
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    enable = 1'b1;
    step();
  endtask

  task automatic wait_valid(input int idx, input int budget, output int n);
    n = 0;
    while ((((idx == 0) ? valid_a : valid_b) !== 1'b1) && (n < budget)) begin
      @(negedge clock);
      n++;
    end
    if (((idx == 0) ? valid_a : valid_b) !== 1'b1) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL valid_timeout dut%0d: got no valid, expected one within %0d cycles", idx, budget);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    int seen;
    reset  = 1'b0;
    enable = 1'b0;
    sig_in = 1'b0;
    repeat (3) step();
    check_output("reset_count", int'(count_a), 0);
    check_output("reset_ovf",   int'(ovf_a),   0);
    check_output("reset_valid", int'(valid_a), 0);

    $display("[TB] release reset with enable high");
    reset  = 1'b1;
    enable = 1'b1;
    wait_valid(0, 40, n);
    check_output("first_valid_latency", n, 21);
    check_output("first_window_count", int'(count_a), 0);

    $display("[TB] basic count");
    start_window();
    apply_stimulus(5, 2, 2);
    wait_valid(0, 10, n);
    check_output("basic_count", int'(count_a), 5);
    check_output("basic_ovf",   int'(ovf_a),   0);
    check_output("model_basic", m_count[0],    5);
    step();
    wait_valid(0, 30, n);
    check_output("empty_window_count", int'(count_a), 0);

    $display("[TB] saturation on 40-cycle gate");
    start_window();
    apply_stimulus(18, 1, 1);
    wait_valid(1, 20, n);
    check_output("sat_count", int'(count_b), 15);
    check_output("sat_ovf",   int'(ovf_b),   1);
    check_output("model_sat_ovf", int'(m_ovf[1]), 1);
    apply_stimulus(3, 2, 2);
    wait_valid(1, 60, n);
    check_output("clean_count", int'(count_b), 3);
    check_output("clean_ovf",   int'(ovf_b),   0);

    $display("[TB] edge on window-end cycle");
    start_window();
    apply_stimulus(4, 2, 2);
    step();
    sig_in = 1'b1;
    step();
    step();
    sig_in = 1'b0;
    wait_valid(0, 10, n);
    check_output("boundary_count", int'(count_a), 5);
    step();
    wait_valid(0, 30, n);
    check_output("after_boundary_count", int'(count_a), 0);

    $display("[TB] disable mid-window");
    start_window();
    apply_stimulus(6, 1, 2);
    wait_valid(0, 10, n);
    check_output("pre_disable_count", int'(count_a), 6);
    step();
    apply_stimulus(3, 1, 2);
    enable = 1'b0;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (valid_a === 1'b1) seen++;
    end
    check_output("disabled_valids", seen, 0);
    check_output("disabled_hold_count", int'(count_a), 6);
    enable = 1'b1;
    apply_stimulus(2, 2, 2);
    wait_valid(0, 40, n);
    check_output("reenable_latency", n + 8, 21);
    check_output("reenable_count", int'(count_a), 2);

    $display("[TB] asynchronous reset mid-window");
    repeat (5) step();
    @(negedge clock);
    #1;
    reset = 1'b0;
    #1;
    check_output("async_reset_count_a", int'(count_a), 0);
    check_output("async_reset_ovf_a",   int'(ovf_a),   0);
    check_output("async_reset_valid_a", int'(valid_a), 0);
    check_output("async_reset_count_b", int'(count_b), 0);
    check_output("async_reset_ovf_b",   int'(ovf_b),   0);
    repeat (2) step();
    reset  = 1'b1;
    enable = 1'b1;
    wait_valid(0, 40, n);
    check_output("post_reset_latency", n, 21);

    $display("[TB] randomized asynchronous input");
    for (int i = 0; i < 600; i++) begin
      step();
      sig_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) enable = ~enable;
      else if (!enable && $urandom_range(0, 3) == 0) enable = 1'b1;
    end
    sig_in = 1'b0;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule
